// File: rtl/irr_priority_resolver.sv
// IRR capture and priority resolution for the PIC: synchronizes IR lines, latches edge/level requests,
// and resolves the highest unmasked request against in-service state. Optional macro: SPECIAL_MASK_MODE_EN.
module irr_priority_resolver #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [2:0]  RESET_LOWEST = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  input  logic       smm,
  input  logic       inta_active,
  input  logic       ack_strobe,
  input  logic       prio_load,
  input  logic [2:0] prio_lowest,
  output logic [7:0] irr,
  output logic [7:0] irr_highest_bit,
  output logic       higher_priority,
  output logic       int_req,
  output logic [2:0] lowest_prio
);

  logic [SYNC_STAGES-1:0][7:0] sync_reg;
  logic [7:0] ir_s;
  logic [7:0] ir_d_reg;

  logic [7:0] irr_reg, irr_next;
  logic [7:0] highest_reg, highest_next;
  logic       higher_reg, higher_next;
  logic       int_reg;
  logic [2:0] lowest_reg;

  logic [7:0] cand;
  logic [7:0] isr_eff;
  logic [2:0] start_lvl;
  logic [7:0] cand_rot, isr_rot;
  logic [3:0] cand_rank, isr_rank;
  logic [2:0] cand_lvl;
  logic       cand_any;

  // Input synchronizer; stage 0 faces the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      ir_d_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ir};
      ir_d_reg <= ir_s;
    end
  end

  assign ir_s = sync_reg[SYNC_STAGES-1];

  // Edge mode: a fresh rising edge beats a simultaneous acknowledge of the same bit.
  for (genvar gi = 0; gi < 8; gi++) begin : g_irr
    logic rise;
    logic ack_hit;
    assign rise    = ir_s[gi] & ~ir_d_reg[gi];
    assign ack_hit = ack_strobe & highest_reg[gi];
    assign irr_next[gi] = ltim ? (ir_s[gi] & ~ack_hit)
                               : (rise | (ir_s[gi] & ~ack_hit & irr_reg[gi]));
  end

  assign cand = irr_reg & ~imr;

`ifdef SPECIAL_MASK_MODE_EN
  assign isr_eff = smm ? (isr & ~imr) : isr;
`else
  logic unused_smm;
  assign unused_smm = smm;
  assign isr_eff    = isr;
`endif

  // Rotate both vectors so index 0 is the highest-priority level; 3-bit adds wrap mod 8.
  assign start_lvl = lowest_reg + 3'd1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    logic [2:0] lvl;
    assign lvl          = start_lvl + 3'(gi);
    assign cand_rot[gi] = cand[lvl];
    assign isr_rot[gi]  = isr_eff[lvl];
  end

  always_comb begin
    cand_rank = 4'd8;
    isr_rank  = 4'd8;
    for (int r = 7; r >= 0; r--) begin
      if (cand_rot[r]) cand_rank = 4'(r);
      if (isr_rot[r])  isr_rank  = 4'(r);
    end
  end

  assign cand_any     = |cand;
  assign cand_lvl     = start_lvl + cand_rank[2:0];
  assign highest_next = cand_any ? (8'd1 << cand_lvl) : 8'd0;
  assign higher_next  = cand_any && (cand_rank < isr_rank);

  // Resolution outputs hold through INTA so the in-service register sees a stable vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irr_reg     <= '0;
      highest_reg <= '0;
      higher_reg  <= 1'b0;
      int_reg     <= 1'b0;
      lowest_reg  <= RESET_LOWEST;
    end else begin
      irr_reg <= irr_next;
      if (prio_load) lowest_reg <= prio_lowest;
      if (!inta_active) begin
        highest_reg <= highest_next;
        higher_reg  <= higher_next;
        int_reg     <= higher_reg;
      end
    end
  end

  assign irr             = irr_reg;
  assign irr_highest_bit = highest_reg;
  assign higher_priority = higher_reg;
  assign int_req         = int_reg;
  assign lowest_prio     = lowest_reg;

endmodule
